dual_port_ram_core: RTL

DUAL_PORT_RAM_CORE -- requirements
Module: dual_port_ram_core

---
 rtl/dual_port_ram_core.sv | 138 +++++++++++++
 1 files changed

// File: rtl/dual_port_ram_core.sv
// Dual-port RAM core: one write port, one two-stage pipelined read port with
// write-first forwarding, per-word written flags (unwritten words read as
// zero) and saturating write/read/collision statistics counters.
module dual_port_ram_core #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 12,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] wr_add,
  input  logic [DATA_WIDTH-1:0] in,
  input  logic                  rd,
  input  logic [ADDR_WIDTH-1:0] rd_add,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  rd_valid,
  output logic [CNT_WIDTH-1:0]  wr_count,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic [CNT_WIDTH-1:0]  coll_count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // Storage array has no reset so it can map onto block RAM; validity of a
  // word is tracked by the separate written-flag vector instead.
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_raw_q;

  logic [DEPTH-1:0]      written_q, written_d;

  // Stage 1: captured read request plus the write-first bypass seen at capture
  logic                  s1_valid_q, s1_valid_d;
  logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
  logic                  s1_written_q, s1_written_d;
  logic                  s1_fwd_q, s1_fwd_d;
  logic [DATA_WIDTH-1:0] s1_fwd_data_q, s1_fwd_data_d;

  // Stage 2: output register and statistics
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [CNT_WIDTH-1:0]  wr_count_q, wr_count_d;
  logic [CNT_WIDTH-1:0]  rd_count_q, rd_count_d;
  logic [CNT_WIDTH-1:0]  coll_count_q, coll_count_d;

  logic                  same_edge_hit;
  logic                  late_fwd;
  logic [DATA_WIDTH-1:0] s1_data;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c,
                                                   input logic en);
    if (en && (c != CNT_MAX)) return c + 1'b1;
    return c;
  endfunction

  // Memory write port; writes are suppressed while reset is held
  always_ff @(posedge clk) begin
    if (wr && rst_n) mem[wr_add] <= in;
  end

  // Registered memory read (returns pre-write contents on a same-edge hit)
  always_ff @(posedge clk) begin
    if (rd) rd_raw_q <= mem[rd_add];
  end

  assign same_edge_hit = wr && rd && (wr_add == rd_add);
  assign late_fwd      = wr && s1_valid_q && (wr_add == s1_addr_q);
  assign s1_data       = s1_fwd_q ? s1_fwd_data_q : rd_raw_q;

  // Next-state: written flags, stage-1 capture, output select and counters
  always_comb begin
    written_d     = written_q;
    s1_valid_d    = rd;
    s1_addr_d     = s1_addr_q;
    s1_written_d  = s1_written_q;
    s1_fwd_d      = s1_fwd_q;
    s1_fwd_data_d = s1_fwd_data_q;
    out_d         = out_q;
    rd_valid_d    = 1'b0;
    wr_count_d    = sat_inc(wr_count_q, wr);
    rd_count_d    = sat_inc(rd_count_q, s1_valid_q);
    coll_count_d  = sat_inc(coll_count_q, same_edge_hit);

    if (wr) written_d[wr_add] = 1'b1;

    if (rd) begin
      s1_addr_d     = rd_add;
      s1_fwd_d      = same_edge_hit;
      s1_fwd_data_d = in;
      s1_written_d  = written_q[rd_add] | same_edge_hit;
    end

    // A write landing on the in-flight address at completion wins over memory
    if (s1_valid_q) begin
      rd_valid_d = 1'b1;
      if (late_fwd)          out_d = in;
      else if (s1_written_q) out_d = s1_data;
      else                   out_d = '0;
    end
  end

  // Control and pipeline state register with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      written_q     <= '0;
      s1_valid_q    <= 1'b0;
      s1_addr_q     <= '0;
      s1_written_q  <= 1'b0;
      s1_fwd_q      <= 1'b0;
      s1_fwd_data_q <= '0;
      out_q         <= '0;
      rd_valid_q    <= 1'b0;
      wr_count_q    <= '0;
      rd_count_q    <= '0;
      coll_count_q  <= '0;
    end else begin
      written_q     <= written_d;
      s1_valid_q    <= s1_valid_d;
      s1_addr_q     <= s1_addr_d;
      s1_written_q  <= s1_written_d;
      s1_fwd_q      <= s1_fwd_d;
      s1_fwd_data_q <= s1_fwd_data_d;
      out_q         <= out_d;
      rd_valid_q    <= rd_valid_d;
      wr_count_q    <= wr_count_d;
      rd_count_q    <= rd_count_d;
      coll_count_q  <= coll_count_d;
    end
  end

  assign out        = out_q;
  assign rd_valid   = rd_valid_q;
  assign wr_count   = wr_count_q;
  assign rd_count   = rd_count_q;
  assign coll_count = coll_count_q;

endmodule
